regfile_sb: RTL and testbench
=============================

REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter WORD_WIDTH, default 16, sets the data word width in bits.
REQ-002 Parameter IDX_WIDTH, default 4, sets the register index width; NUM_REGS = 2**IDX_WIDTH.
REQ-003 Parameter NUM_RD, default 2, range 1..4, sets the number of read ports.
REQ-004 Parameter BYPASS, default 1, enables write-to-read forwarding (1) or disables it (0).
REQ-005 clock  input  1  the single clock; all state changes on its rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_write  input  1  writeback strobe.
REQ-008 in_dst_idx  input  IDX_WIDTH  writeback register index.
REQ-009 in_dst  input  WORD_WIDTH  writeback data.
REQ-010 in_issue  input  1  marks a register as pending, i.e. an outstanding producer.
REQ-011 in_issue_idx  input  IDX_WIDTH  index to mark pending.
REQ-012 in_src_idx  input  NUM_RD*IDX_WIDTH  packed read indices; port k occupies bits [k*IDX_WIDTH +: IDX_WIDTH].
REQ-013 out_src  output  NUM_RD*WORD_WIDTH  packed read data, packed the same way as in_src_idx.
REQ-014 out_busy  output  NUM_RD  per-port flag: the source register is pending.
REQ-015 out_err  output  2  sticky error flags: bit0 = write to reg0, bit1 = writeback to a non-pending register.
REQ-016 out_pending  output  NUM_REGS  per-register busy (scoreboard) bits.

Function
REQ-017 Register 0 SHALL always read 0; writes to it SHALL be discarded and SHALL set out_err[0].
REQ-018 A write with in_write=1 and in_dst_idx!=0 SHALL update the register at the next rising edge.
REQ-019 Reads SHALL be combinational: out_src port k = registers[idx_k].
REQ-020 With BYPASS=1, when in_write=1, in_dst_idx==idx_k and idx_k!=0, port k SHALL return in_dst in the same cycle.
REQ-021 With BYPASS=0, port k SHALL return the stored value until the edge after the write.
REQ-022 An issue with in_issue=1 and in_issue_idx!=0 SHALL set pending[in_issue_idx] at the next edge; an issue to reg0 SHALL be ignored.
REQ-023 A write to a register index SHALL clear its pending bit at the next edge.
REQ-024 When an issue and a write target the same index in the same cycle, the issue SHALL win and the pending bit SHALL remain 1.
REQ-025 out_busy[k] SHALL equal pending[idx_k], except that it SHALL be 0 when BYPASS=1 and a same-cycle write hits idx_k.
REQ-026 A write to a register whose pending bit is 0 SHALL still update the data and SHALL set out_err[1].
REQ-027 The out_err bits SHALL be sticky until reset.
REQ-028 All read ports SHALL operate independently; identical indices on several ports SHALL return identical data.

Reset
REQ-029 Asserting reset_n=0 SHALL immediately clear all registers, all pending bits and out_err, regardless of clock.
REQ-030 While in reset, out_src SHALL be 0, out_busy 0 and out_pending 0.
REQ-031 A write or issue presented in the cycle reset_n deasserts SHALL take effect at the first rising edge with reset_n=1.
REQ-032 A reset asserted in the middle of an operation SHALL discard all outstanding pending state.

Structure
REQ-033 A shared package regfile_pkg SHALL hold the default widths, the NUM_RD limit and the out_err bit-position constants.
REQ-034 One sub-module, regfile_rdport (index-to-data mux plus bypass compare), SHALL be instantiated NUM_RD times by generate.
REQ-035 Storage and the scoreboard SHALL live in regfile_sb; there SHALL be no latches.

Verification
REQ-036 Reset, then write r3=0x1234, then read port0 idx3 -> 0x1234 and out_busy[0]=0.
REQ-037 BYPASS=1: write r5=0xBEEF while port1 reads idx5 in the same cycle -> out_src port1=0xBEEF, busy 0; with BYPASS=0 -> old value 0x0000.
REQ-038 Write r0=0xFFFF -> reads of idx0 return 0, and out_err=2'b01.
REQ-039 Issue r7, then read idx7 -> busy 1; write r7=0x00AA -> busy 0 the next cycle; issue and write r7 in the same cycle -> pending[7] stays 1.
REQ-040 Write r9 with no prior issue -> out_err[1]=1 and r9 updated.
REQ-041 Issue r2 and write r4, then assert reset_n=0 mid-cycle -> all outputs 0 immediately; after release r4 reads 0 and pending[2]=0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the scoreboarded register file: default geometry,
// read-port limit and sticky error bit positions.
package regfile_pkg;

   localparam int unsigned DEF_WORD_WIDTH  = 16;
   localparam int unsigned DEF_IDX_WIDTH   = 4;
   localparam int unsigned DEF_NUM_RD      = 2;
   localparam int unsigned MAX_NUM_RD      = 4;

   localparam int unsigned ERR_W           = 2;
   localparam int unsigned ERR_WR_REG0     = 0;
   localparam int unsigned ERR_WR_NOT_PEND = 1;

endpackage

// File: rtl/regfile_rdport.sv
// One read port: index-to-data mux with optional same-cycle writeback
// forwarding and the matching scoreboard busy flag.
module regfile_rdport
   import regfile_pkg::*;
#(
   parameter  int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
   parameter  int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
   parameter  int unsigned BYPASS     = 1,
   localparam int unsigned NUM_REGS   = 32'(1) << IDX_WIDTH
) (
   input  logic                                i_en,
   input  logic [NUM_REGS-1:0][WORD_WIDTH-1:0] i_regs,
   input  logic [NUM_REGS-1:0]                 i_pending,
   input  logic                                i_write,
   input  logic [IDX_WIDTH-1:0]                i_dst_idx,
   input  logic [WORD_WIDTH-1:0]               i_dst,
   input  logic [IDX_WIDTH-1:0]                i_src_idx,
   output logic [WORD_WIDTH-1:0]               o_data_c,
   output logic                                o_busy_c
);

   logic w_hit;

   // Reg0 is never forwarded so it keeps reading as zero.
   assign w_hit = (BYPASS != 0) && i_write && (i_dst_idx == i_src_idx) &&
                  (i_src_idx != '0);

   always_comb begin
      o_data_c = '0;
      o_busy_c = 1'b0;
      if (i_en) begin
         o_data_c = w_hit ? i_dst : i_regs[i_src_idx];
         o_busy_c = !w_hit && i_pending[i_src_idx];
      end
   end

endmodule

// File: rtl/regfile_sb.sv
// Register file with per-register pending scoreboard, NUM_RD combinational
// read ports, optional writeback forwarding and sticky error flags.
module regfile_sb
   import regfile_pkg::*;
#(
   parameter  int unsigned WORD_WIDTH = DEF_WORD_WIDTH,
   parameter  int unsigned IDX_WIDTH  = DEF_IDX_WIDTH,
   parameter  int unsigned NUM_RD     = DEF_NUM_RD,
   parameter  int unsigned BYPASS     = 1,
   localparam int unsigned NUM_REGS   = 32'(1) << IDX_WIDTH
) (
   input  logic                         clock,
   input  logic                         reset_n,
   input  logic                         in_write,
   input  logic [IDX_WIDTH-1:0]         in_dst_idx,
   input  logic [WORD_WIDTH-1:0]        in_dst,
   input  logic                         in_issue,
   input  logic [IDX_WIDTH-1:0]         in_issue_idx,
   input  logic [NUM_RD*IDX_WIDTH-1:0]  in_src_idx,
   output logic [NUM_RD*WORD_WIDTH-1:0] out_src,
   output logic [NUM_RD-1:0]            out_busy,
   output logic [ERR_W-1:0]             out_err,
   output logic [NUM_REGS-1:0]          out_pending
);

   logic [NUM_REGS-1:0][WORD_WIDTH-1:0] r_regs;
   logic [NUM_REGS-1:0]                 r_pending;
   logic [NUM_REGS-1:0]                 w_pending_nxt;
   logic [ERR_W-1:0]                    r_err;
   logic [ERR_W-1:0]                    w_err_set;
   logic                                w_wr_valid;
   logic                                w_iss_valid;

   assign w_wr_valid  = in_write && (in_dst_idx != '0);
   assign w_iss_valid = in_issue && (in_issue_idx != '0);

   // Issue is applied after writeback so a same-index issue keeps the bit set.
   always_comb begin
      w_pending_nxt = r_pending;
      if (w_wr_valid)  w_pending_nxt[in_dst_idx]   = 1'b0;
      if (w_iss_valid) w_pending_nxt[in_issue_idx] = 1'b1;
      w_err_set                  = '0;
      w_err_set[ERR_WR_REG0]     = in_write && (in_dst_idx == '0);
      w_err_set[ERR_WR_NOT_PEND] = w_wr_valid && !r_pending[in_dst_idx];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_regs    <= '0;
         r_pending <= '0;
         r_err     <= '0;
      end else begin
         if (w_wr_valid) r_regs[in_dst_idx] <= in_dst;
         r_pending <= w_pending_nxt;
         r_err     <= r_err | w_err_set;
      end
   end

   assign out_pending = r_pending;
   assign out_err     = r_err;

   // Read ports are gated by reset_n so a forwarded write cannot leak out in reset.
   for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
      regfile_rdport #(
         .WORD_WIDTH (WORD_WIDTH),
         .IDX_WIDTH  (IDX_WIDTH),
         .BYPASS     (BYPASS)
      ) u_rdport (
         .i_en      (reset_n),
         .i_regs    (r_regs),
         .i_pending (r_pending),
         .i_write   (in_write),
         .i_dst_idx (in_dst_idx),
         .i_dst     (in_dst),
         .i_src_idx (in_src_idx[k*IDX_WIDTH +: IDX_WIDTH]),
         .o_data_c  (out_src[k*WORD_WIDTH +: WORD_WIDTH]),
         .o_busy_c  (out_busy[k])
      );
   end

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a forwarding and a non-forwarding instance share
// stimulus and are compared against an array-based reference model.
module tb_regfile_sb;

   localparam int unsigned WW   = 16;
   localparam int unsigned IW   = 4;
   localparam int unsigned NR   = 2;
   localparam int unsigned NREG = 16;

   logic              clock = 1'b0;
   logic              reset_n;
   logic              in_write;
   logic [IW-1:0]     in_dst_idx;
   logic [WW-1:0]     in_dst;
   logic              in_issue;
   logic [IW-1:0]     in_issue_idx;
   logic [NR*IW-1:0]  in_src_idx;

   logic [NR*WW-1:0]  src_b,  src_n;
   logic [NR-1:0]     busy_b, busy_n;
   logic [1:0]        err_b,  err_n;
   logic [NREG-1:0]   pend_b, pend_n;

   int n_checks = 0;
   int n_errors = 0;

   logic [WW-1:0] m_regs [NREG];
   bit            m_pend [NREG];
   logic [1:0]    m_err;

   always #5 clock = ~clock;

   regfile_sb #(.WORD_WIDTH(WW), .IDX_WIDTH(IW), .NUM_RD(NR), .BYPASS(1)) u_byp (
      .clock(clock), .reset_n(reset_n), .in_write(in_write), .in_dst_idx(in_dst_idx),
      .in_dst(in_dst), .in_issue(in_issue), .in_issue_idx(in_issue_idx),
      .in_src_idx(in_src_idx), .out_src(src_b), .out_busy(busy_b),
      .out_err(err_b), .out_pending(pend_b));

   regfile_sb #(.WORD_WIDTH(WW), .IDX_WIDTH(IW), .NUM_RD(NR), .BYPASS(0)) u_nobyp (
      .clock(clock), .reset_n(reset_n), .in_write(in_write), .in_dst_idx(in_dst_idx),
      .in_dst(in_dst), .in_issue(in_issue), .in_issue_idx(in_issue_idx),
      .in_src_idx(in_src_idx), .out_src(src_n), .out_busy(busy_n),
      .out_err(err_n), .out_pending(pend_n));

   // ---------------- reference model ----------------
   function automatic void model_reset();
      for (int i = 0; i < int'(NREG); i++) begin
         m_regs[i] = '0;
         m_pend[i] = 1'b0;
      end
      m_err = 2'b00;
   endfunction

   function automatic void model_step();
      int d = int'(in_dst_idx);
      int s = int'(in_issue_idx);
      if (in_write) begin
         if (d == 0) m_err[0] = 1'b1;
         else begin
            if (!m_pend[d]) m_err[1] = 1'b1;
            m_regs[d] = in_dst;
            m_pend[d] = 1'b0;
         end
      end
      if (in_issue && s != 0) m_pend[s] = 1'b1;
   endfunction

   function automatic logic [WW-1:0] exp_data(bit byp, int k);
      int s = int'(in_src_idx[k*IW +: IW]);
      if (!reset_n) return '0;
      if (byp && in_write && int'(in_dst_idx) == s && s != 0) return in_dst;
      return m_regs[s];
   endfunction

   function automatic logic exp_busy(bit byp, int k);
      int s = int'(in_src_idx[k*IW +: IW]);
      if (!reset_n) return 1'b0;
      if (byp && in_write && int'(in_dst_idx) == s && s != 0) return 1'b0;
      return m_pend[s];
   endfunction

   function automatic logic [NREG-1:0] exp_pend();
      logic [NREG-1:0] v;
      for (int i = 0; i < int'(NREG); i++) v[i] = m_pend[i];
      return v;
   endfunction

   // ---------------- stimulus helpers ----------------
   task automatic drive(input logic w, input logic [IW-1:0] didx, input logic [WW-1:0] d,
                        input logic iss, input logic [IW-1:0] iidx,
                        input logic [IW-1:0] s0, input logic [IW-1:0] s1);
      @(negedge clock);
      in_write     = w;
      in_dst_idx   = didx;
      in_dst       = d;
      in_issue     = iss;
      in_issue_idx = iidx;
      in_src_idx   = {s1, s0};
   endtask

   task automatic tick();
      @(posedge clock);
      if (reset_n) model_step();
      #1;
   endtask

   task automatic do_reset();
      @(negedge clock);
      reset_n = 1'b0;
      model_reset();
      in_write = 1'b0; in_issue = 1'b0;
      @(negedge clock);
      reset_n = 1'b1;
   endtask

   // ---------------- tests ----------------
   task automatic test_reset();
      reset_n = 1'b0;
      model_reset();
      in_write = 1'b1; in_dst_idx = IW'(5); in_dst = 16'hBEEF;
      in_issue = 1'b1; in_issue_idx = IW'(5); in_src_idx = {IW'(5), IW'(5)};
      #1;
      n_checks++; if (src_b !== '0 || src_n !== '0) begin n_errors++;
         $display("FAIL reset_src: got %h/%h exp 0", src_b, src_n); end
      n_checks++; if (busy_b !== '0 || busy_n !== '0) begin n_errors++;
         $display("FAIL reset_busy: got %b/%b exp 0", busy_b, busy_n); end
      tick(); tick();
      n_checks++; if (pend_b !== '0 || pend_n !== '0 || err_b !== 2'b00 || err_n !== 2'b00) begin
         n_errors++; $display("FAIL reset_state: pend %h/%h err %b/%b exp 0", pend_b, pend_n, err_b, err_n); end
      // release with a write already presented: it must land on the first edge
      @(negedge clock);
      reset_n = 1'b1;
      in_write = 1'b1; in_dst_idx = IW'(3); in_dst = 16'h1234;
      in_issue = 1'b0; in_src_idx = {IW'(0), IW'(3)};
      tick();
      drive(0, 0, 0, 0, 0, 3, 3);
      #1;
      n_checks++; if (src_b[15:0] !== 16'h1234 || src_n[15:0] !== 16'h1234) begin n_errors++;
         $display("FAIL r3_read: got %h/%h exp 1234", src_b[15:0], src_n[15:0]); end
      n_checks++; if (busy_b[0] !== 1'b0 || busy_n[0] !== 1'b0) begin n_errors++;
         $display("FAIL r3_busy: got %b/%b exp 0", busy_b[0], busy_n[0]); end
      n_checks++; if (err_b !== m_err || err_n !== m_err) begin n_errors++;
         $display("FAIL r3_err: got %b/%b exp %b", err_b, err_n, m_err); end
   endtask

   task automatic test_bypass();
      do_reset();
      drive(1, 5, 16'hBEEF, 0, 0, 3, 5);
      #1;
      n_checks++; if (src_b[31:16] !== 16'hBEEF || busy_b[1] !== 1'b0) begin n_errors++;
         $display("FAIL byp_fwd: got %h busy %b exp BEEF busy 0", src_b[31:16], busy_b[1]); end
      n_checks++; if (src_n[31:16] !== 16'h0000) begin n_errors++;
         $display("FAIL nobyp_old: got %h exp 0000", src_n[31:16]); end
      tick();
      drive(0, 0, 0, 0, 0, 5, 5);
      #1;
      n_checks++; if (src_b !== {16'hBEEF, 16'hBEEF} || src_n !== {16'hBEEF, 16'hBEEF}) begin n_errors++;
         $display("FAIL byp_after: got %h/%h exp BEEFBEEF", src_b, src_n); end
      drive(0, 0, 0, 1, 6, 0, 0);
      tick();
      drive(1, 6, 16'h1111, 0, 0, 6, 6);
      #1;
      n_checks++; if (busy_b !== 2'b00 || busy_n !== 2'b11) begin n_errors++;
         $display("FAIL byp_busy: got %b/%b exp 00/11", busy_b, busy_n); end
      n_checks++; if (src_b[31:16] !== 16'h1111 || src_n[31:16] !== 16'h0000) begin n_errors++;
         $display("FAIL byp_pend_fwd: got %h/%h exp 1111/0000", src_b[31:16], src_n[31:16]); end
      tick();
   endtask

   task automatic test_reg0();
      do_reset();
      drive(1, 0, 16'hFFFF, 0, 0, 0, 0);
      #1;
      n_checks++; if (src_b !== '0 || src_n !== '0) begin n_errors++;
         $display("FAIL reg0_fwd: got %h/%h exp 0", src_b, src_n); end
      tick();
      drive(0, 0, 0, 0, 0, 0, 0);
      #1;
      n_checks++; if (src_b !== '0 || src_n !== '0) begin n_errors++;
         $display("FAIL reg0_read: got %h/%h exp 0", src_b, src_n); end
      n_checks++; if (err_b !== 2'b01 || err_n !== 2'b01) begin n_errors++;
         $display("FAIL reg0_err: got %b/%b exp 01", err_b, err_n); end
   endtask

   task automatic test_pending();
      do_reset();
      drive(0, 0, 0, 1, 7, 7, 7);
      tick();
      drive(0, 0, 0, 0, 0, 7, 7);
      #1;
      n_checks++; if (busy_b !== 2'b11 || busy_n !== 2'b11 || pend_b[7] !== 1'b1) begin n_errors++;
         $display("FAIL issue_busy: got %b/%b pend %b exp 11/11 pend 1", busy_b, busy_n, pend_b[7]); end
      drive(1, 7, 16'h00AA, 0, 0, 7, 7);
      #1;
      n_checks++; if (busy_b !== 2'b00 || busy_n !== 2'b11) begin n_errors++;
         $display("FAIL wb_same_cycle_busy: got %b/%b exp 00/11", busy_b, busy_n); end
      tick();
      drive(0, 0, 0, 0, 0, 7, 7);
      #1;
      n_checks++; if (busy_b !== 2'b00 || busy_n !== 2'b00 || pend_n[7] !== 1'b0) begin n_errors++;
         $display("FAIL wb_clear: got %b/%b pend %b exp 00/00 pend 0", busy_b, busy_n, pend_n[7]); end
      n_checks++; if (src_n[15:0] !== 16'h00AA || err_b !== 2'b00) begin n_errors++;
         $display("FAIL wb_data: got %h err %b exp 00AA err 00", src_n[15:0], err_b); end
      drive(1, 7, 16'h0055, 1, 7, 7, 7);
      tick();
      drive(0, 0, 0, 1, 0, 7, 0);
      tick();
      n_checks++; if (pend_b[7] !== 1'b1 || pend_n[7] !== 1'b1) begin n_errors++;
         $display("FAIL issue_wins: got %b/%b exp 1", pend_b[7], pend_n[7]); end
      n_checks++; if (pend_b[0] !== 1'b0 || src_b[15:0] !== 16'h0055 || busy_b[0] !== 1'b1) begin n_errors++;
         $display("FAIL issue_r0_data: pend0 %b data %h busy %b exp 0 0055 1", pend_b[0], src_b[15:0], busy_b[0]); end
   endtask

   task automatic test_nopend_write();
      do_reset();
      drive(1, 9, 16'h5A5A, 0, 0, 9, 9);
      tick();
      drive(0, 0, 0, 0, 0, 9, 9);
      #1;
      n_checks++; if (err_b !== 2'b10 || err_n !== 2'b10) begin n_errors++;
         $display("FAIL nopend_err: got %b/%b exp 10", err_b, err_n); end
      n_checks++; if (src_b !== {16'h5A5A, 16'h5A5A}) begin n_errors++;
         $display("FAIL nopend_data: got %h exp 5A5A5A5A", src_b); end
   endtask

   task automatic test_reset_mid();
      do_reset();
      drive(1, 4, 16'hCAFE, 1, 3, 4, 3);
      tick();
      drive(1, 4, 16'h7777, 1, 2, 4, 3);
      #3;
      reset_n = 1'b0;
      model_reset();
      #1;
      n_checks++; if (src_b !== '0 || src_n !== '0 || busy_b !== '0 || busy_n !== '0) begin n_errors++;
         $display("FAIL midrst_read: src %h/%h busy %b/%b exp 0", src_b, src_n, busy_b, busy_n); end
      n_checks++; if (pend_b !== '0 || pend_n !== '0 || err_b !== '0 || err_n !== '0) begin n_errors++;
         $display("FAIL midrst_state: pend %h/%h err %b/%b exp 0", pend_b, pend_n, err_b, err_n); end
      drive(0, 0, 0, 0, 0, 4, 2);
      reset_n = 1'b1;
      #1;
      n_checks++; if (src_b[15:0] !== 16'h0000 || src_n[15:0] !== 16'h0000) begin n_errors++;
         $display("FAIL midrst_r4: got %h/%h exp 0", src_b[15:0], src_n[15:0]); end
      tick();
      n_checks++; if (pend_b[2] !== 1'b0 || pend_b !== '0) begin n_errors++;
         $display("FAIL midrst_pend: got %h exp 0", pend_b); end
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         logic [IW-1:0] s0, s1, di;
         s0 = IW'($urandom_range(0, NREG - 1));
         s1 = ($urandom_range(0, 3) == 0) ? s0 : IW'($urandom_range(0, NREG - 1));
         di = ($urandom_range(0, 2) == 0) ? s1 : IW'($urandom_range(0, NREG - 1));
         drive(1'($urandom_range(0, 1)), di, WW'($urandom),
               1'($urandom_range(0, 1)), IW'($urandom_range(0, NREG - 1)), s0, s1);
         #1;
         for (int k = 0; k < int'(NR); k++) begin
            n_checks++; if (src_b[k*WW +: WW] !== exp_data(1'b1, k)) begin n_errors++;
               $display("FAIL rand_src_byp c%0d p%0d: got %h exp %h", c, k, src_b[k*WW +: WW], exp_data(1'b1, k)); end
            n_checks++; if (src_n[k*WW +: WW] !== exp_data(1'b0, k)) begin n_errors++;
               $display("FAIL rand_src_nobyp c%0d p%0d: got %h exp %h", c, k, src_n[k*WW +: WW], exp_data(1'b0, k)); end
            n_checks++; if (busy_b[k] !== exp_busy(1'b1, k) || busy_n[k] !== exp_busy(1'b0, k)) begin n_errors++;
               $display("FAIL rand_busy c%0d p%0d: got %b/%b exp %b/%b", c, k, busy_b[k], busy_n[k],
                        exp_busy(1'b1, k), exp_busy(1'b0, k)); end
         end
         tick();
         n_checks++; if (pend_b !== exp_pend() || pend_n !== exp_pend()) begin n_errors++;
            $display("FAIL rand_pend c%0d: got %h/%h exp %h", c, pend_b, pend_n, exp_pend()); end
         n_checks++; if (err_b !== m_err || err_n !== m_err) begin n_errors++;
            $display("FAIL rand_err c%0d: got %b/%b exp %b", c, err_b, err_n, m_err); end
      end
   endtask

   initial begin
      test_reset();
      test_bypass();
      test_reg0();
      test_pending();
      test_nopend_write();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
